ssdisplay_mux: RTL

SSDISPLAY_MUX -- requirements
Module: ssdisplay_mux

---
 rtl/ssdisplay_mux_if.sv | 17 +
 rtl/ssdisplay_mux.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ssdisplay_mux_if.sv
// rtl/ssdisplay_mux_if.sv - load/convert handshake and display drive bundle for ssdisplay_mux
interface ssdisplay_mux_if #(
   parameter int DATA_W = 6,
   parameter int DIGITS = 2
);
   logic [DATA_W-1:0] data;
   logic              load;
   logic              blank_lz;
   logic              busy;
   logic              done;
   logic              ovf;
   logic [7:0]        seg;
   logic [DIGITS-1:0] an;

   modport master (output data, load, blank_lz, input busy, done, ovf, seg, an);
   modport slave  (input data, load, blank_lz, output busy, done, ovf, seg, an);
endinterface

// File: rtl/ssdisplay_mux.sv
// rtl/ssdisplay_mux.sv - binary to BCD (double dabble) converter driving a multiplexed 7-segment display
module ssdisplay_mux #(
   parameter int DATA_W   = 6,
   parameter int DIGITS   = 2,
   parameter int SCAN_DIV = 50000
) (
   input logic             clk,
   input logic             rst,
   ssdisplay_mux_if.slave  bus
);
   // Nibble count covers the whole DATA_W range so overflow beyond DIGITS is detectable.
   localparam int NIB_RAW = (DATA_W + 2) / 3;
   localparam int NIB     = (NIB_RAW > DIGITS) ? NIB_RAW : DIGITS;
   localparam int BW      = NIB * 4;
   localparam int DW      = DIGITS * 4;
   localparam int CW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int SW      = $clog2(SCAN_DIV);
   localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_CONV = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic [BW-1:0]     bcd_q, bcd_d;
   logic [BW-1:0]     bcd_adj, bcd_step;
   logic [DW-1:0]     disp_q, disp_d;
   logic              ovf_q, ovf_d;
   logic [SW-1:0]     scan_q, scan_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [7:0]        seg_q, seg_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [DW-1:0]     upper;
   logic              last;
   logic              lz;

   function automatic logic [7:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 8'hC0;
         4'd1:    glyph = 8'hF9;
         4'd2:    glyph = 8'hA4;
         4'd3:    glyph = 8'hB0;
         4'd4:    glyph = 8'h99;
         4'd5:    glyph = 8'h92;
         4'd6:    glyph = 8'h82;
         4'd7:    glyph = 8'hF8;
         4'd8:    glyph = 8'h80;
         4'd9:    glyph = 8'h90;
         default: glyph = 8'hFF;
      endcase
   endfunction

   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < NIB; i++) begin
         bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
      end
      bcd_step = (bcd_adj << 1) | BW'(sh_q[DATA_W-1]);
   end

   assign last = (cnt_q == CW'(DATA_W - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      bcd_d   = bcd_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.load) begin
               sh_d    = bus.data;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = ST_CONV;
            end
         end
         default: begin
            bcd_d = bcd_step;
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               state_d = ST_IDLE;
               disp_d  = bcd_step[DW-1:0];
               ovf_d   = |(bcd_step >> DW);
            end
         end
      endcase
   end

   always_comb begin
      scan_d = scan_q + 1'b1;
      idx_d  = idx_q;
      if (scan_q == SW'(SCAN_DIV - 1)) begin
         scan_d = '0;
         idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      upper = disp_q >> (4 * idx_q);
      lz    = bus.blank_lz && (idx_q != '0) && (upper == '0);
      if (ovf_q)
         seg_d = 8'hBF;
      else if (lz)
         seg_d = 8'hFF;
      else
         seg_d = glyph(upper[3:0]);
      an_d = ~(DIGITS'(1) << idx_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         bcd_q   <= '0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         scan_q  <= '0;
         idx_q   <= '0;
         seg_q   <= 8'hFF;
         an_q    <= '1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         bcd_q   <= bcd_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign bus.busy = (state_q == ST_CONV);
   assign bus.done = (state_q == ST_CONV) && last;
   assign bus.ovf  = ovf_q;
   assign bus.seg  = seg_q;
   assign bus.an   = an_q;
endmodule
